countdown_timer: RTL and testbench

//  Consumes the ~1 Hz square wave from the clock divider as a sampled input, not as a clock.

---
 rtl/countdown_timer_if.sv | 31 +++
 rtl/countdown_timer.sv | 141 ++++++++++++++
 tb/tb_countdown_timer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control and display bus of the countdown timer.
//   start, stop, load : 1-cycle command pulses from game control
//   min_tens..sec_ones: BCD MM:SS digits to the display mux
//   running, expired  : status levels
//   expired_pulse     : 1-cycle pulse on entry to expiry
interface countdown_timer_if;
  logic       start;
  logic       stop;
  logic       load;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       expired;
  logic       expired_pulse;

  // Game control side: issues commands, observes digits and status.
  modport master (
    output start, stop, load,
    input  min_tens, min_ones, sec_tens, sec_ones,
    input  running, expired, expired_pulse
  );

  // Timer side.
  modport slave (
    input  start, stop, load,
    output min_tens, min_ones, sec_tens, sec_ones,
    output running, expired, expired_pulse
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer driven by a sampled ~1 Hz square wave.
//   clkin   : system clock (the only clock)
//   reset   : synchronous active-low reset
//   tick_in : divider square wave, asynchronous to clkin; each rising edge
//             becomes one 1-cycle tick after a two-flop synchroniser
//   bus     : commands (start/stop/load) in, digits and status out
// START_MIN / START_SEC give the reload value in binary.
module countdown_timer #(
  parameter int unsigned START_MIN = 3,
  parameter int unsigned START_SEC = 0
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                tick_in,
  countdown_timer_if.slave    bus
);

  localparam int unsigned DIGIT_W = 4;

  if (START_MIN > 99 || START_SEC > 59) begin : g_bad_start
    $error("countdown_timer: START_MIN must be 0..99 and START_SEC 0..59");
  end

  localparam logic [DIGIT_W-1:0] RELOAD_MT = DIGIT_W'(START_MIN / 10);
  localparam logic [DIGIT_W-1:0] RELOAD_MO = DIGIT_W'(START_MIN % 10);
  localparam logic [DIGIT_W-1:0] RELOAD_ST = DIGIT_W'(START_SEC / 10);
  localparam logic [DIGIT_W-1:0] RELOAD_SO = DIGIT_W'(START_SEC % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t             state;
  logic               s0, s1, s2;
  logic               tick_c;
  logic [DIGIT_W-1:0] mt, mo, st, so;
  logic [DIGIT_W-1:0] dec_mt_c, dec_mo_c, dec_st_c, dec_so_c;
  logic               is_zero_c, is_one_c;
  logic               running_q, expired_q, expired_pulse_q;

  // Rising edge of the synchronised square wave; s0/s1 form the synchroniser.
  assign tick_c = s1 & ~s2;

  assign is_zero_c = (mt == '0) && (mo == '0) && (st == '0) && (so == '0);
  assign is_one_c  = (mt == '0) && (mo == '0) && (st == '0) && (so == DIGIT_W'(1));

  // One-second BCD decrement with borrow chain; never used at 00:00.
  always_comb begin
    dec_mt_c = mt;
    dec_mo_c = mo;
    dec_st_c = st;
    dec_so_c = so - DIGIT_W'(1);
    if (so == '0) begin
      dec_so_c = DIGIT_W'(9);
      dec_st_c = st - DIGIT_W'(1);
      if (st == '0) begin
        dec_st_c = DIGIT_W'(5);
        dec_mo_c = mo - DIGIT_W'(1);
        if (mo == '0) begin
          dec_mo_c = DIGIT_W'(9);
          dec_mt_c = mt - DIGIT_W'(1);
        end
      end
    end
  end

  // Control FSM, synchroniser and digit registers.
  always_ff @(posedge clkin) begin
    if (!reset) begin
      state           <= IDLE;
      s0              <= 1'b0;
      s1              <= 1'b0;
      s2              <= 1'b0;
      mt              <= RELOAD_MT;
      mo              <= RELOAD_MO;
      st              <= RELOAD_ST;
      so              <= RELOAD_SO;
      running_q       <= 1'b0;
      expired_q       <= 1'b0;
      expired_pulse_q <= 1'b0;
    end else begin
      s0              <= tick_in;
      s1              <= s0;
      s2              <= s1;
      expired_pulse_q <= 1'b0;
      if (bus.load) begin
        state     <= IDLE;
        mt        <= RELOAD_MT;
        mo        <= RELOAD_MO;
        st        <= RELOAD_ST;
        so        <= RELOAD_SO;
        running_q <= 1'b0;
        expired_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start && !is_zero_c) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            // stop outranks a coincident tick: pause without decrementing.
            if (bus.stop) begin
              state     <= PAUSE;
              running_q <= 1'b0;
            end else if (tick_c) begin
              mt <= dec_mt_c;
              mo <= dec_mo_c;
              st <= dec_st_c;
              so <= dec_so_c;
              if (is_one_c) begin
                state           <= DONE;
                running_q       <= 1'b0;
                expired_q       <= 1'b1;
                expired_pulse_q <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (bus.start) begin
              state     <= RUN;
              running_q <= 1'b1;
            end
          end
          DONE: begin
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.min_tens      = mt;
  assign bus.min_ones      = mo;
  assign bus.sec_tens      = st;
  assign bus.sec_ones      = so;
  assign bus.running       = running_q;
  assign bus.expired       = expired_q;
  assign bus.expired_pulse = expired_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer: instance a reloads 00:03, instance b 10:00.
// Both share clock, reset and tick_in; each has its own command bus.
module tb_countdown_timer;

  logic clkin   = 1'b0;
  logic reset   = 1'b0;
  logic tick_in = 1'b0;

  always #5 clkin = ~clkin;

  countdown_timer_if bus_a ();
  countdown_timer_if bus_b ();

  countdown_timer #(.START_MIN(0), .START_SEC(3)) dut_a (
    .clkin   (clkin),
    .reset   (reset),
    .tick_in (tick_in),
    .bus     (bus_a.slave)
  );

  countdown_timer #(.START_MIN(10), .START_SEC(0)) dut_b (
    .clkin   (clkin),
    .reset   (reset),
    .tick_in (tick_in),
    .bus     (bus_b.slave)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: remaining time in whole seconds plus two status flags.
  int m_secs   [2];
  int m_reload [2];
  bit m_run    [2];
  bit m_exp    [2];

  function automatic void model_reload(int i);
    m_secs[i] = m_reload[i];
    m_run[i]  = 1'b0;
    m_exp[i]  = 1'b0;
  endfunction

  function automatic void model_start(int i);
    if (!m_run[i] && !m_exp[i] && m_secs[i] != 0) m_run[i] = 1'b1;
  endfunction

  function automatic void model_stop(int i);
    m_run[i] = 1'b0;
  endfunction

  function automatic void model_tick(int i);
    if (m_run[i]) begin
      m_secs[i] = m_secs[i] - 1;
      if (m_secs[i] == 0) begin
        m_run[i] = 1'b0;
        m_exp[i] = 1'b1;
      end
    end
  endfunction

  // {mm tens, mm ones, ss tens, ss ones, running, expired, expired_pulse}
  function automatic logic [18:0] exp_word(int i, bit pulse);
    int mm, ss;
    mm = m_secs[i] / 60;
    ss = m_secs[i] % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), m_run[i], m_exp[i], pulse};
  endfunction

  function automatic logic [18:0] obs(int i);
    if (i == 0)
      return {bus_a.min_tens, bus_a.min_ones, bus_a.sec_tens, bus_a.sec_ones,
              bus_a.running, bus_a.expired, bus_a.expired_pulse};
    return {bus_b.min_tens, bus_b.min_ones, bus_b.sec_tens, bus_b.sec_ones,
            bus_b.running, bus_b.expired, bus_b.expired_pulse};
  endfunction

  // which: 0 start, 1 stop, 2 load, 3 load+start together
  task automatic pulse_ctl(int i, int which);
    @(negedge clkin);
    if (i == 0) begin
      bus_a.start = (which == 0 || which == 3);
      bus_a.stop  = (which == 1);
      bus_a.load  = (which == 2 || which == 3);
    end else begin
      bus_b.start = (which == 0 || which == 3);
      bus_b.stop  = (which == 1);
      bus_b.load  = (which == 2 || which == 3);
    end
    @(negedge clkin);
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.load = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.load = 1'b0;
    case (which)
      0: model_start(i);
      1: model_stop(i);
      default: model_reload(i);
    endcase
  endtask

  // One full tick_in period; high long enough for the tick to land.
  task automatic tick_period(int hi, int lo);
    @(negedge clkin);
    tick_in = 1'b1;
    repeat (hi) @(negedge clkin);
    tick_in = 1'b0;
    repeat (lo) @(negedge clkin);
    model_tick(0);
    model_tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clkin);
    reset = 1'b1;
    model_reload(0);
    model_reload(1);
    @(negedge clkin);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL reset_a: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
    checks++;
    if (obs(1) !== exp_word(1, 1'b0))
      $display("FAIL reset_b: got %h want %h", obs(1), exp_word(1, 1'b0));
    else passed++;
  endtask

  task automatic test_countdown();
    pulse_ctl(0, 0);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL start_run: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(negedge clkin);
      tick_in = 1'b1;
      @(negedge clkin);
      @(negedge clkin);
      checks++;
      if (obs(0) !== exp_word(0, 1'b0))
        $display("FAIL tick_early_%0d: got %h want %h", k, obs(0), exp_word(0, 1'b0));
      else passed++;
      @(negedge clkin);
      model_tick(0);
      model_tick(1);
      checks++;
      if (obs(0) !== exp_word(0, k == 2))
        $display("FAIL tick_land_%0d: got %h want %h", k, obs(0), exp_word(0, k == 2));
      else passed++;
      if (k == 2) begin
        @(negedge clkin);
        checks++;
        if (obs(0) !== exp_word(0, 1'b0))
          $display("FAIL pulse_clear: got %h want %h", obs(0), exp_word(0, 1'b0));
        else passed++;
      end
      repeat (17) @(negedge clkin);
      tick_in = 1'b0;
      repeat (20) @(negedge clkin);
    end
  endtask

  task automatic test_pause();
    pulse_ctl(0, 2);
    pulse_ctl(0, 0);
    tick_period(20, 20);
    pulse_ctl(0, 1);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL pause_enter: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
    for (int k = 0; k < 5; k++) tick_period(20, 20);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL pause_frozen: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
    pulse_ctl(0, 0);
    tick_period(20, 20);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL pause_resume: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
  endtask

  task automatic test_borrow();
    pulse_ctl(0, 2);
    pulse_ctl(1, 2);
    pulse_ctl(1, 0);
    tick_period(20, 20);
    checks++;
    if (obs(1) !== exp_word(1, 1'b0))
      $display("FAIL borrow_0959: got %h want %h", obs(1), exp_word(1, 1'b0));
    else passed++;
    pulse_ctl(1, 2);
  endtask

  task automatic test_done();
    pulse_ctl(0, 2);
    pulse_ctl(0, 0);
    for (int k = 0; k < 3; k++) tick_period(20, 20);
    pulse_ctl(0, 0);
    tick_period(20, 20);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL done_hold: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
    pulse_ctl(0, 2);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL done_load: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
    pulse_ctl(0, 0);
    tick_period(20, 20);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL done_restart: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
  endtask

  task automatic test_same_edge();
    pulse_ctl(0, 2);
    pulse_ctl(0, 0);
    // tick_in sampled at edge N; stop held across edge N+2 where the tick lands.
    @(negedge clkin);
    tick_in = 1'b1;
    @(negedge clkin);
    @(negedge clkin);
    bus_a.stop = 1'b1;
    @(negedge clkin);
    bus_a.stop = 1'b0;
    model_stop(0);
    repeat (10) @(negedge clkin);
    tick_in = 1'b0;
    repeat (10) @(negedge clkin);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL stop_with_tick: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
    pulse_ctl(0, 0);
    pulse_ctl(0, 3);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL load_with_start: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
    pulse_ctl(0, 0);
    tick_period(20, 20);
    @(negedge clkin);
    reset = 1'b0;
    @(negedge clkin);
    reset = 1'b1;
    model_reload(0);
    model_reload(1);
    checks++;
    if (obs(0) !== exp_word(0, 1'b0))
      $display("FAIL reset_mid_run: got %h want %h", obs(0), exp_word(0, 1'b0));
    else passed++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int op, sel;
      op  = int'($urandom_range(0, 4));
      sel = int'($urandom_range(0, 1));
      case (op)
        0, 1, 2: pulse_ctl(sel, op);
        3: tick_period(int'($urandom_range(3, 20)), int'($urandom_range(3, 20)));
        default: repeat (int'($urandom_range(1, 5))) @(negedge clkin);
      endcase
      checks++;
      if (obs(0) !== exp_word(0, 1'b0))
        $display("FAIL random_a_%0d op %0d: got %h want %h", n, op, obs(0), exp_word(0, 1'b0));
      else passed++;
      checks++;
      if (obs(1) !== exp_word(1, 1'b0))
        $display("FAIL random_b_%0d op %0d: got %h want %h", n, op, obs(1), exp_word(1, 1'b0));
      else passed++;
    end
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.load = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.load = 1'b0;
    m_reload[0] = 3;
    m_reload[1] = 600;
    model_reload(0);
    model_reload(1);
    test_reset();
    test_countdown();
    test_pause();
    test_borrow();
    test_done();
    test_same_edge();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
